test_controller: RTL and testbench

- Synthesizable run controller for the RV32I core bench; successor to the fixed-delay reset/finish bench sequence.
- Holds the core in reset for a parameterised number of cycles, then lets it run.
- Counts cycles and retired instructions.
- Ends the run on a tohost-style store (pass/fail plus exit code) or on a cycle-budget timeout.
- Sits beside `top`: snoops its data-memory write port and drives the core's active-high reset.

---
 rtl/test_controller.sv | 116 +++++++++++
 tb/tb_test_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/test_controller.sv
// Run controller for the RV32I core bench: holds the core in reset,
// counts cycles/retires, and ends the run on a tohost store or timeout.
module test_controller #(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter int                CNT_W        = 32,
  parameter int                RESET_CYCLES = 10,
  parameter int                MAX_CYCLES   = 100,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 'h0000_0FFC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              retire,
  output logic              core_reset,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-2:0] exit_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count
);

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_e;

  state_e            state_q;
  logic [HW-1:0]     hold_q;
  logic              core_reset_q;
  logic              done_q;
  logic              pass_q;
  logic              timeout_q;
  logic [DATA_W-2:0] exit_q;
  logic [CNT_W-1:0]  cyc_q;
  logic [CNT_W-1:0]  ret_q;

  logic              tohost;
  logic [DATA_W-2:0] code;

  // Only odd words terminate; bit 0 marks the store as a tohost message.
  assign tohost = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
  assign code   = mem_wdata[DATA_W-1:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_HOLD;
      hold_q       <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      exit_q       <= '0;
      cyc_q        <= '0;
      ret_q        <= '0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          hold_q <= hold_q + HW'(1);
          if (hold_q == HOLD_LAST) begin
            state_q      <= S_RUN;
            core_reset_q <= 1'b0;
          end
        end
        S_RUN: begin
          cyc_q <= cyc_q + CNT_W'(1);
          if (retire) ret_q <= ret_q + CNT_W'(1);
          if (tohost) begin
            state_q      <= (code == '0) ? S_PASS : S_FAIL;
            exit_q       <= code;
            pass_q       <= (code == '0);
            done_q       <= 1'b1;
            core_reset_q <= 1'b1;
          end else if (cyc_q == CYC_LAST) begin
            state_q      <= S_TIMEOUT;
            timeout_q    <= 1'b1;
            done_q       <= 1'b1;
            core_reset_q <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            state_q   <= S_HOLD;
            hold_q    <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            exit_q    <= '0;
            cyc_q     <= '0;
            ret_q     <= '0;
          end
        end
      endcase
    end
  end

  assign core_reset   = core_reset_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign exit_code    = exit_q;
  assign cycle_count  = cyc_q;
  assign retire_count = ret_q;

endmodule

// File: tb/tb_test_controller.sv
// Directed bench for test_controller: vector table of run endings
// plus hand sequences for restart and mid-run reset.
module tb_test_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        retire = 1'b0;
  logic        core_reset;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [30:0] exit_code;
  logic [31:0] cycle_count;
  logic [31:0] retire_count;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  test_controller dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .retire       (retire),
    .core_reset   (core_reset),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .exit_code    (exit_code),
    .cycle_count  (cycle_count),
    .retire_count (retire_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    int          at;
    int          mode;
    logic        e_done;
    logic        e_pass;
    logic        e_tmo;
    logic [30:0] e_code;
    int          e_cyc;
    int          e_rc;
  } vec_t;

  vec_t v[9];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic e_cr,
                           input logic e_done, input logic e_pass,
                           input logic e_tmo, input logic [30:0] e_code,
                           input int e_cyc, input int e_rc);
    chk({tag, ".core_reset"}, 64'(core_reset), 64'(e_cr));
    chk({tag, ".done"}, 64'(done), 64'(e_done));
    chk({tag, ".pass"}, 64'(pass), 64'(e_pass));
    chk({tag, ".timeout"}, 64'(timeout), 64'(e_tmo));
    chk({tag, ".exit_code"}, 64'(exit_code), 64'(e_code));
    chk({tag, ".cycle_count"}, 64'(cycle_count), 64'(e_cyc));
    chk({tag, ".retire_count"}, 64'(retire_count), 64'(e_rc));
  endtask

  task automatic idle();
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    retire    = 1'b0;
    start     = 1'b0;
  endtask

  // Counts rising edges at which core_reset is seen high.
  task automatic hold_phase(input string tag, input int mode);
    int n;
    n = 0;
    retire = (mode == 1);
    mem_we = 1'b1;
    mem_addr = 32'h0000_0FFC;
    mem_wdata = 32'h1;
    while (core_reset === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({tag, ".hold_edges"}, 64'(n), 64'd10);
    chk({tag, ".cyc_at_run"}, 64'(cycle_count), 64'd0);
    idle();
  endtask

  task automatic begin_run(input string tag, input int mode);
    idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    hold_phase(tag, mode);
  endtask

  task automatic run_store(input int at, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic we,
                           input int mode, input int start_k);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 130) begin
      mem_we    = (k == at) ? we : 1'b0;
      mem_addr  = addr;
      mem_wdata = wdata;
      retire    = (mode == 1) ? 1'b1 : ((mode == 2) ? k[0] : 1'b0);
      start     = (k == start_k);
      @(negedge clk);
      k++;
    end
    idle();
  endtask

  task automatic late_store();
    mem_we    = 1'b1;
    mem_addr  = 32'h0000_0FFC;
    mem_wdata = 32'h1;
    retire    = 1'b1;
    repeat (3) @(negedge clk);
    idle();
  endtask

  initial begin
    v[0] = '{32'hFFC, 32'h1, 1'b1, 40, 1, 1'b1, 1'b1, 1'b0, 31'h0, 41, 41};
    v[1] = '{32'hFFC, 32'h7, 1'b1, 10, 2, 1'b1, 1'b0, 1'b0, 31'h3, 11, 5};
    v[2] = '{32'hFFC, 32'h2, 1'b1, 20, 1, 1'b1, 1'b0, 1'b1, 31'h0, 100, 100};
    v[3] = '{32'hFF8, 32'h1, 1'b1, 30, 0, 1'b1, 1'b0, 1'b1, 31'h0, 100, 0};
    v[4] = '{32'hFFC, 32'h1, 1'b1, 99, 1, 1'b1, 1'b1, 1'b0, 31'h0, 100, 100};
    v[5] = '{32'hFFC, 32'hFFFF_FFFF, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0,
             31'h7FFF_FFFF, 1, 0};
    v[6] = '{32'hFFC, 32'h8000_0001, 1'b1, 5, 2, 1'b1, 1'b0, 1'b0,
             31'h4000_0000, 6, 3};
    v[7] = '{32'hFFC, 32'h1, 1'b1, 98, 0, 1'b1, 1'b1, 1'b0, 31'h0, 99, 0};
    v[8] = '{32'hFFC, 32'h1, 1'b0, 15, 2, 1'b1, 1'b0, 1'b1, 31'h0, 100, 50};

    #1 reset = 1'b0;
    #2 check_out("por", 1'b1, 1'b0, 1'b0, 1'b0, 31'h0, 0, 0);
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      begin_run(tag, v[i].mode);
      run_store(v[i].at, v[i].addr, v[i].wdata, v[i].we, v[i].mode, 3);
      late_store();
      check_out(tag, 1'b1, v[i].e_done, v[i].e_pass, v[i].e_tmo,
                v[i].e_code, v[i].e_cyc, v[i].e_rc);
    end

    begin_run("rs0", 0);
    run_store(30, 32'hFFC, 32'h1, 1'b1, 0, -1);
    check_out("rs0", 1'b1, 1'b1, 1'b1, 1'b0, 31'h0, 31, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_out("rs_clr", 1'b1, 1'b0, 1'b0, 1'b0, 31'h0, 0, 0);
    hold_phase("rs1", 1);
    run_store(20, 32'hFFC, 32'h1, 1'b1, 1, 5);
    check_out("rs1", 1'b1, 1'b1, 1'b1, 1'b0, 31'h0, 21, 21);

    begin_run("mr", 1);
    retire = 1'b1;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_out("mr_rst", 1'b1, 1'b0, 1'b0, 1'b0, 31'h0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    hold_phase("mr_rel", 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
